// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative HI/LO multiply/divide unit (MULTU/DIVU/MTHI/MTLO).
// Ports: clk, rst (sync, active-low), start/op/a/b/flush in; busy/done/stall/hi/lo out.
// Define MULDIV_SIGNED_EN to also accept MULT (op 101) and DIV (op 110).
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t state;

  // MUL: {partial product, remaining multiplier bits}
  // DIV: {partial remainder, dividend/quotient bits}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      cnt;

  logic is_mul, is_div, is_mthi, is_mtlo, sgn;

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    sgn     = 1'b0;
    unique case (op)
      3'b001: is_mul  = 1'b1;
      3'b010: is_div  = 1'b1;
      3'b011: is_mthi = 1'b1;
      3'b100: is_mtlo = 1'b1;
`ifdef MULDIV_SIGNED_EN
      3'b101: begin
        is_mul = 1'b1;
        sgn    = 1'b1;
      end
      3'b110: begin
        is_div = 1'b1;
        sgn    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;
  assign stall = start & busy;

`ifdef MULDIV_SIGNED_EN
  logic             neg_lo, neg_hi, div0;
  logic [WIDTH-1:0] a_keep;
  logic [2*WIDTH-1:0] prod;
`endif

  logic [WIDTH:0]     mul_sum, rem_sh, div_dif;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, step;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + (acc[0] ? {1'b0, opnd} : '0);
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_dif = rem_sh - {1'b0, opnd};
    // Borrow out of bit WIDTH means the trial subtract failed: restore.
    div_nxt = div_dif[WIDTH]
            ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
            : {div_dif[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    step   = (state == S_DIV) ? div_nxt : mul_nxt;
    res_hi = step[2*WIDTH-1:WIDTH];
    res_lo = step[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    prod = -step;
    if (state == S_MUL) begin
      if (neg_lo) begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
      end
    end else begin
      if (neg_lo) res_lo = -step[WIDTH-1:0];
      if (neg_hi) res_hi = -step[2*WIDTH-1:WIDTH];
      // Sign fix-up would corrupt the x/0 result, so force it.
      if (div0) begin
        res_hi = a_keep;
        res_lo = '1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      acc   <= '0;
      opnd  <= '0;
      cnt   <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
      a_keep <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !flush) begin
            unique case (1'b1)
              is_mthi: hi <= a;
              is_mtlo: lo <= a;
              is_mul: begin
                state <= S_MUL;
                busy  <= 1'b1;
                acc   <= {{WIDTH{1'b0}}, b_mag};
                opnd  <= a_mag;
                cnt   <= '0;
              end
              is_div: begin
                state <= S_DIV;
                busy  <= 1'b1;
                acc   <= {{WIDTH{1'b0}}, a_mag};
                opnd  <= b_mag;
                cnt   <= '0;
              end
              default: ;
            endcase
`ifdef MULDIV_SIGNED_EN
            neg_lo <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi <= sgn & a[WIDTH-1];
            div0   <= (b == '0);
            a_keep <= a;
`endif
          end
        end
        default: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (cnt == LAST) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            acc <= step;
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: directed scoreboard bench for mips_muldiv (WIDTH=32).
// Expected HI/LO pushed at issue, popped on done.
module tb_mips_muldiv;
  localparam int W = 32;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIVU  = 3'b010;
  localparam logic [2:0] MTHI  = 3'b011;
  localparam logic [2:0] MTLO  = 3'b100;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, stall;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] sb_q[$];

  mips_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .flush(flush), .busy(busy),
    .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with start dropped.
  task automatic start_op(input logic [2:0] o,
                          input logic [W-1:0] x,
                          input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    op    = '0;
  endtask

  task automatic go(input logic [2:0] o,
                    input logic [W-1:0] x,
                    input logic [W-1:0] y,
                    input logic [2*W-1:0] exp);
    sb_q.push_back(exp);
    start_op(o, x, y);
  endtask

  task automatic wait_done(input string tag, input int exp_n);
    int n = 0;
    logic [2*W-1:0] e;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, ".busy_len"}, 64'(n), 64'(exp_n));
    check({tag, ".done"}, 64'(done), 64'd1);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".hilo"}, {hi, lo}, e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [W-1:0] x, y;
    logic [2*W-1:0] keep;
    int ndone;

    repeat (2) @(negedge clk);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.hilo", {hi, lo}, 64'd0);
    check("rst.stall", 64'(stall), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    go(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    wait_done("multu_max", W);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);

    go(DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    start = 1'b1;
    op    = MTHI;
    a     = 32'hAAAA_AAAA;
    #1;
    check("stall_hi", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    op    = '0;
    #1;
    check("stall_lo", 64'(stall), 64'd0);
    wait_done("divu", W - 1);

    // Issued in the done cycle of the previous op.
    go(DIVU, 32'h1234, 32'd0, {32'h1234, 32'hFFFFFFFF});
    wait_done("div0", W);

    for (int i = 0; i < 3; i++) begin
      x = $urandom;
      y = $urandom;
      go(MULTU, x, y, 64'(x) * 64'(y));
      wait_done("rand_mul", W);
    end
    for (int i = 0; i < 3; i++) begin
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if (y == 0) y = 1;
      go(DIVU, x, y, {x % y, x / y});
      wait_done("rand_div", W);
    end

    keep = {hi, lo};
    start_op(3'b111, 32'h1, 32'h2);
    check("op7.busy", 64'(busy), 64'd0);
    check("op7.hilo", {hi, lo}, keep);

    do_reset();
    @(negedge clk);
    start_op(MTHI, 32'hDEADBEEF, '0);
    check("mthi.hi", 64'(hi), 64'hDEADBEEF);
    check("mthi.busy", 64'(busy), 64'd0);
    check("mthi.done", 64'(done), 64'd0);
    start_op(MULTU, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush.busy", 64'(busy), 64'd0);
    ndone = 0;
    for (int i = 0; i < W + 2; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    check("flush.nodone", 64'(ndone), 64'd0);
    check("flush.hilo", {hi, lo}, {32'hDEADBEEF, 32'h0});

    start = 1'b1;
    flush = 1'b1;
    op    = MULTU;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    check("flush_start.busy", 64'(busy), 64'd0);

    start_op(MTLO, 32'h55, '0);
    check("mtlo.lo", 64'(lo), 64'h55);
    start_op(MULTU, 32'd2, 32'd2);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.done", 64'(done), 64'd0);
    check("midrst.hilo", {hi, lo}, 64'd0);
    go(MULTU, 32'd2, 32'd3, 64'd6);
    wait_done("mul_after_rst", W);

`ifdef MULDIV_SIGNED_EN
    go(3'b101, -32'sd3, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    wait_done("mult_neg", W);
    go(3'b110, -32'sd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    wait_done("div_neg", W);
    go(3'b110, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
    wait_done("div_ovf", W);
    go(3'b110, -32'sd5, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF});
    wait_done("div_s0", W);
`else
    keep = {hi, lo};
    start = 1'b1;
    op    = 3'b101;
    a     = 32'h7;
    b     = 32'h9;
    #1;
    check("op5.stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0;
    op    = '0;
    check("op5.busy", 64'(busy), 64'd0);
    check("op5.hilo", {hi, lo}, keep);
    start_op(3'b110, 32'h7, 32'h9);
    check("op6.busy", 64'(busy), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width.
- Sits beside the EX-stage ALU of the 5-stage pipeline and executes MULTU/DIVU/MTHI/MTLO (signed MULT/DIV optional).
- Pipeline control uses stall to hold IF/ID/EX while a new request meets an in-progress operation, and uses flush to cancel on branch/jump.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (>=4); iteration count = WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset
- start  in  1  request valid this cycle
- op  in  3  000 none, 001 MULTU, 010 DIVU, 011 MTHI, 100 MTLO, 101 MULT, 110 DIV, 111 reserved
- a  in  WIDTH  operand A / MTHI-MTLO data
- b  in  WIDTH  operand B
- flush  in  1  cancel in-progress operation
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse when HI/LO updated by MUL/DIV
- stall  out  1  start & busy (combinational)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst==0 at edge): state IDLE, hi=lo=0, busy=0, done=0, working registers and counter cleared. Reset mid-operation aborts it and HI/LO become 0.
- States:
  - IDLE: if start & valid op, latch operands into working regs.
    - MUL ops go to MUL, DIV ops go to DIV.
    - MTHI/MTLO write hi/lo=a at the next edge, stay IDLE, no busy, no done.
  - MUL: shift-add, 1 bit/cycle, WIDTH cycles, 2*WIDTH-bit accumulator.
  - DIV: restoring divide, 1 quotient bit/cycle, WIDTH cycles.
  - On the edge ending the last iteration: commit hi/lo, return to IDLE, done=1 for exactly the following cycle.
- Latency: request accepted in cycle t; busy=1 in cycles t+1..t+WIDTH; hi/lo valid and done=1 in cycle t+WIDTH+1, with busy=0 in that cycle.
- A new request is acceptable in the done cycle.
- Results:
  - MUL: {hi,lo} = a*b, full 2*WIDTH bits.
  - DIV: lo = quotient, hi = remainder.
- Divide by zero: lo = all ones, hi = a; normal latency.
- HI/LO are not modified until commit. Working state is separate, so hi/lo hold their pre-op values during busy.
- start while busy: ignored, stall=1. Requester must hold start/op/a/b until stall=0.
- op 000/111 or unsupported op with start: ignored, no state change.
- flush: if busy, return to IDLE at the next edge, no commit, no done, hi/lo unchanged. flush+start in the same cycle: flush wins, start ignored. flush in IDLE is a no-op. flush in the done cycle does not undo the commit.
- Counter width ceil(log2(WIDTH))+1. All arithmetic is unsigned modulo width unless the optional feature is enabled.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - op 101 (MULT) and 110 (DIV) are accepted; operands are converted to magnitude at accept and the sign is fixed at commit, with the same latency.
  - MULT: two's-complement 2*WIDTH-bit product.
  - DIV: quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Overflow case min_int/-1: lo = min_int, hi = 0.
  - Divide by zero: lo = all ones, hi = a.
- Undefined: op 101/110 are treated as unsupported (ignored, busy stays 0, stall=0).

Test Plan:
1. Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high exactly 32 cycles, then done pulse with hi=0xFFFFFFFE, lo=0x00000001.
2. DIVU a=100 b=7 -> lo=14, hi=2. Start MTHI during busy -> stall=1, ignored, hi=2 after done.
3. DIVU a=0x1234 b=0 -> after 32 cycles lo=0xFFFFFFFF, hi=0x00001234.
4. MTHI 0xDEADBEEF; next cycle MULTU 3*5; flush at busy cycle 5 -> busy=0 next cycle, no done, hi=0xDEADBEEF, lo=0.
5. MTLO 0x55; MULTU 2*2; rst=0 at busy cycle 10 -> next cycle busy=0, done=0, hi=lo=0. Subsequent MULTU 2*3 gives lo=6.
6. With MULDIV_SIGNED_EN:
   - MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
   - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
   - Without macro: op=101 -> busy stays 0, hi/lo unchanged.
